seq_shifter: RTL and testbench

Multi-cycle, parametrised shifter/rotator for the pipelined CPU datapath, succeeding the fixed 16-bit single-position combinational shifter. It accepts an operand, a variable shift amount and a mode through a valid/ready handshake. It shifts up to STEP positions per clock and returns the result, with the last bit shifted out, through a second valid/ready handshake. It sits beside the ALU in the execute stage; the pipeline stalls on `in_ready`/`out_valid`.

---
 rtl/seq_shifter.sv | 163 ++++++++++++++++
 tb/tb_seq_shifter.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/seq_shifter.sv
// Multi-cycle shifter/rotator: up to STEP positions per clock, valid/ready in and out.
// Optional NZC flag output enabled by defining SEQ_SHIFTER_FLAGS_EN.
module seq_shifter #(
    parameter int WIDTH = 16,
    parameter int STEP  = 4,
    parameter int AMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [AMT_W-1:0] in_amt,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_carry,
    output logic [2:0]       out_flags
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

    localparam logic [1:0] MODE_ROR = 2'b00;
    localparam logic [1:0] MODE_LSL = 2'b01;
    localparam logic [1:0] MODE_LSR = 2'b10;
    localparam logic [1:0] MODE_ASR = 2'b11;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [AMT_W-1:0] rem_q, rem_d;
    logic [1:0]       mode_q, mode_d;
    logic             carry_q, carry_d;
    logic             last_step;
    int               rem_i;
    int               step_k;

    // One k-position step (1 <= k < WIDTH); returns {carry, result}.
    function automatic logic [WIDTH:0] shift_step(
        input logic [WIDTH-1:0] din,
        input logic [1:0]       mode,
        input int               k
    );
        logic signed [WIDTH-1:0] sdin;
        logic [WIDTH-1:0]        res;
        logic [WIDTH-1:0]        tap;
        sdin = $signed(din);
        res  = din;
        tap  = din >> (k - 1);
        case (mode)
            MODE_LSL: begin
                res = din << k;
                tap = din >> (WIDTH - k);
            end
            MODE_LSR: res = din >> k;
            MODE_ASR: res = $unsigned(sdin >>> k);
            default:  res = (din >> k) | (din << (WIDTH - k));
        endcase
        return {tap[0], res};
    endfunction

    always_comb begin
        rem_i     = int'(rem_q);
        step_k    = (rem_i < STEP) ? rem_i : STEP;
        last_step = (rem_i <= STEP);
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: every accepted request passes through SHIFT at least once,
    // so a zero amount takes one cycle just like amounts 1..STEP.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid)  state_d = SHIFT;
            SHIFT:   if (last_step) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        data_d  = data_q;
        rem_d   = rem_q;
        mode_d  = mode_q;
        carry_d = carry_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    data_d  = in_data;
                    rem_d   = in_amt;
                    mode_d  = in_mode;
                    carry_d = 1'b0;
                end
            end
            SHIFT: begin
                if (step_k > 0) begin
                    {carry_d, data_d} = shift_step(data_q, mode_q, step_k);
                    rem_d             = AMT_W'(rem_i - step_k);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q  <= '0;
            rem_q   <= '0;
            mode_q  <= '0;
            carry_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            rem_q   <= rem_d;
            mode_q  <= mode_d;
            carry_q <= carry_d;
        end
    end

`ifdef SEQ_SHIFTER_FLAGS_EN
    logic [2:0] flags_q, flags_d;

    // Flags are captured only on entry to DONE so they stay aligned with the held result.
    always_comb begin
        flags_d = flags_q;
        if (state_q == SHIFT && last_step) begin
            flags_d = {data_d[WIDTH-1], (data_d == '0), carry_d};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flags_q <= 3'b000;
        end else begin
            flags_q <= flags_d;
        end
    end

    assign out_flags = flags_q;
`else
    assign out_flags = 3'b000;
`endif

    // Outputs
    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
        out_data  = data_q;
        out_carry = carry_q;
    end

endmodule

// File: tb/tb_seq_shifter.sv
// Directed self-checking bench for seq_shifter (WIDTH=16, STEP=4).
module tb_seq_shifter;

    localparam int WIDTH = 16;
    localparam int STEP  = 4;
    localparam int AMT_W = 4;

    localparam logic [1:0] ROR = 2'b00;
    localparam logic [1:0] LSL = 2'b01;
    localparam logic [1:0] LSR = 2'b10;
    localparam logic [1:0] ASR = 2'b11;

    logic             clk;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [AMT_W-1:0] in_amt;
    logic [1:0]       in_mode;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_carry;
    logic [2:0]       out_flags;

    int n_checks = 0;
    int n_errors = 0;

    seq_shifter #(.WIDTH(WIDTH), .STEP(STEP)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_amt    (in_amt),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_carry (out_carry),
        .out_flags (out_flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [2:0] exp_flags(input logic [2:0] f);
`ifdef SEQ_SHIFTER_FLAGS_EN
        return f;
`else
        return 3'b000;
`endif
    endfunction

    // Called just after a clock edge; returns just after the accept edge with inputs scrambled.
    task automatic start_op(input logic [WIDTH-1:0] d, input logic [AMT_W-1:0] a, input logic [1:0] m);
        in_valid = 1'b1;
        in_data  = d;
        in_amt   = a;
        in_mode  = m;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = ~d;
        in_amt   = ~a;
        in_mode  = ~m;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic do_op(input string tag, input logic [WIDTH-1:0] d, input logic [AMT_W-1:0] a,
                         input logic [1:0] m, input logic [WIDTH-1:0] exp_d, input logic exp_c,
                         input logic [2:0] exp_f, input int exp_lat);
        int lat;
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        start_op(d, a, m);
        wait_done(lat);
        check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        check({tag, "_data"}, 32'(out_data), 32'(exp_d));
        check({tag, "_carry"}, 32'(out_carry), 32'(exp_c));
        check({tag, "_flags"}, 32'(out_flags), 32'(exp_flags(exp_f)));
        @(posedge clk);
        #1;
        check({tag, "_consumed"}, {30'd0, out_valid, in_ready}, 32'b01);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int stray;
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_amt    = '0;
        in_mode   = '0;
        out_ready = 1'b1;
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_out_carry", 32'(out_carry), 32'd0);
        check("rst_out_flags", 32'(out_flags), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #3 reset = 1'b0;
        @(posedge clk);
        #1;

        do_op("lsl15",   16'h0001, 4'd15, LSL, 16'h8000, 1'b0, 3'b100, 4);
        do_op("asr2",    16'h8004, 4'd2,  ASR, 16'hE001, 1'b0, 3'b100, 1);
        do_op("asr1",    16'h8003, 4'd1,  ASR, 16'hC001, 1'b1, 3'b101, 1);
        do_op("ror1",    16'h0003, 4'd1,  ROR, 16'h8001, 1'b1, 3'b101, 1);
        do_op("ror8",    16'h1234, 4'd8,  ROR, 16'h3412, 1'b0, 3'b000, 2);
        do_op("lsr15",   16'hFFFF, 4'd15, LSR, 16'h0001, 1'b1, 3'b001, 4);
        do_op("amt0",    16'hBEEF, 4'd0,  LSR, 16'hBEEF, 1'b0, 3'b100, 1);
        do_op("lsl_zero",16'h8000, 4'd1,  LSL, 16'h0000, 1'b1, 3'b011, 1);
        do_op("asr15",   16'h8000, 4'd15, ASR, 16'hFFFF, 1'b0, 3'b100, 4);
        do_op("ror5",    16'h0021, 4'd5,  ROR, 16'h0801, 1'b0, 3'b000, 2);

        // Back-pressure: result held in DONE while a competing request is ignored.
        out_ready = 1'b0;
        start_op(16'h0001, 4'd4, LSL);
        wait_done(lat);
        check("bp_latency", 32'(lat), 32'd1);
        in_valid = 1'b1;
        in_data  = 16'hAAAA;
        in_amt   = 4'd3;
        in_mode  = LSL;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("bp_hold_valid", 32'(out_valid), 32'd1);
            check("bp_hold_data", 32'(out_data), 32'h0010);
            check("bp_hold_carry", 32'(out_carry), 32'd0);
            check("bp_hold_in_ready", 32'(in_ready), 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_release", {30'd0, out_valid, in_ready}, 32'b01);
        do_op("bp_next", 16'hF0F0, 4'd4, LSR, 16'h0F0F, 1'b0, 3'b000, 1);

        // Asynchronous reset in the middle of a multi-cycle shift.
        start_op(16'h00FF, 4'd12, LSL);
        @(posedge clk);
        #1;
        check("mid_busy", {30'd0, out_valid, in_ready}, 32'b00);
        #2 reset = 1'b1;
        #1;
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_out_data", 32'(out_data), 32'd0);
        check("mid_rst_in_ready", 32'(in_ready), 32'd1);
        check("mid_rst_flags", 32'(out_flags), 32'd0);
        #2 reset = 1'b0;
        stray = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) stray++;
        end
        check("mid_no_stale", 32'(stray), 32'd0);
        do_op("post_rst", 16'h00FF, 4'd4, LSR, 16'h000F, 1'b1, 3'b001, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
